// File: rtl/lc4_mem_responder.sv
// ============================================================================
//  lc4_mem_responder
//  Shared instruction/data RAM plus switch, LED and interval-timer I/O page
//  for the LC4 core. Timer logic is built only when LC4_TIMER_EN is defined.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module lc4_mem_responder #(
   parameter int ADDR_BITS  = 10,
   parameter int TIMER_BITS = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        gwe,
   input  logic [15:0] i_imem_addr,
   output logic [15:0] o_imem_data,
   input  logic [15:0] i_dmem_addr,
   input  logic        i_dmem_we,
   input  logic [15:0] i_dmem_towrite,
   output logic [15:0] o_dmem_data,
   input  logic [7:0]  i_switch_data,
   output logic [7:0]  o_led_data,
   output logic        o_timer_irq
);

   localparam logic [15:0] IO_BASE  = 16'hFE00;
   localparam logic [15:0] ADDR_SWR = 16'hFE00;
   localparam logic [15:0] ADDR_LED = 16'hFE02;
   localparam logic [15:0] ADDR_TSR = 16'hFE08;
   localparam logic [15:0] ADDR_TIR = 16'hFE0A;
   localparam int          DEPTH    = 1 << ADDR_BITS;

   logic [15:0]          mem [0:DEPTH-1];
   logic [ADDR_BITS-1:0] imem_idx;
   logic [ADDR_BITS-1:0] dmem_idx;
   logic                 imem_io;
   logic                 dmem_io;
   logic                 ram_we;
   logic                 led_we;
   logic [15:0]          imem_next;
   logic [15:0]          dmem_next;
   logic [15:0]          imem_data;
   logic [15:0]          dmem_data;
   logic [7:0]           led;

   assign imem_idx = i_imem_addr[ADDR_BITS-1:0];
   assign dmem_idx = i_dmem_addr[ADDR_BITS-1:0];
   assign imem_io  = (i_imem_addr >= IO_BASE);
   assign dmem_io  = (i_dmem_addr >= IO_BASE);

   // A reset coinciding with the write edge must discard the write.
   assign ram_we = gwe & i_dmem_we & ~dmem_io & ~rst;
   assign led_we = gwe & i_dmem_we & (i_dmem_addr == ADDR_LED);

`ifdef LC4_TIMER_EN
   logic [TIMER_BITS-1:0] tir;
   logic [TIMER_BITS-1:0] cnt;
   logic                  flag;
   logic                  tir_we;
   logic                  tsr_rd;

   assign tir_we = gwe & i_dmem_we & (i_dmem_addr == ADDR_TIR);
   assign tsr_rd = gwe & ~i_dmem_we & (i_dmem_addr == ADDR_TSR);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tir  <= '0;
         cnt  <= '0;
         flag <= 1'b0;
      end else if (tir_we) begin
         tir <= TIMER_BITS'(i_dmem_towrite);
         cnt <= TIMER_BITS'(i_dmem_towrite);
      end else if (gwe) begin
         if (tir == '0) begin
            cnt <= '0;
            if (tsr_rd) flag <= 1'b0;
         end else if (cnt <= TIMER_BITS'(1)) begin
            // Expiry beats a simultaneous status-read clear.
            flag <= 1'b1;
            cnt  <= tir;
         end else begin
            cnt <= cnt - TIMER_BITS'(1);
            if (tsr_rd) flag <= 1'b0;
         end
      end
   end

   assign o_timer_irq = flag;
`else
   assign o_timer_irq = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (ram_we) mem[dmem_idx] <= i_dmem_towrite;
   end

   always_comb begin
      imem_next = 16'h0000;
      if (!imem_io) imem_next = mem[imem_idx];
   end

   always_comb begin
      dmem_next = 16'h0000;
      if (!dmem_io) begin
         dmem_next = mem[dmem_idx];
      end else begin
         case (i_dmem_addr)
            ADDR_SWR: dmem_next = {8'h00, i_switch_data};
            ADDR_LED: dmem_next = {8'h00, led};
`ifdef LC4_TIMER_EN
            ADDR_TSR: dmem_next = {flag, 15'h0000};
            ADDR_TIR: dmem_next = tir[15:0];
`endif
            default:  dmem_next = 16'h0000;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         imem_data <= 16'h0000;
         dmem_data <= 16'h0000;
         led       <= 8'h00;
      end else if (gwe) begin
         imem_data <= imem_next;
         dmem_data <= dmem_next;
         if (led_we) led <= i_dmem_towrite[7:0];
      end
   end

   assign o_imem_data = imem_data;
   assign o_dmem_data = dmem_data;
   assign o_led_data  = led;

endmodule

`default_nettype wire

// File: tb/tb_lc4_mem_responder.sv
// ============================================================================
//  tb_lc4_mem_responder
//  Self-checking bench: vector table plus timer/gating/reset sequences,
//  expectations queued at drive time and compared after the sampling edge.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_lc4_mem_responder;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        gwe = 1'b0;
   logic [15:0] imem_addr = '0;
   logic [15:0] imem_data;
   logic [15:0] dmem_addr = '0;
   logic        dmem_we = 1'b0;
   logic [15:0] dmem_towrite = '0;
   logic [15:0] dmem_data;
   logic [7:0]  switch_data = '0;
   logic [7:0]  led_data;
   logic        timer_irq;

   int total = 0;
   int bad   = 0;

   lc4_mem_responder #(.ADDR_BITS(10), .TIMER_BITS(16)) dut (
      .clk            (clk),
      .rst            (rst),
      .gwe            (gwe),
      .i_imem_addr    (imem_addr),
      .o_imem_data    (imem_data),
      .i_dmem_addr    (dmem_addr),
      .i_dmem_we      (dmem_we),
      .i_dmem_towrite (dmem_towrite),
      .o_dmem_data    (dmem_data),
      .i_switch_data  (switch_data),
      .o_led_data     (led_data),
      .o_timer_irq    (timer_irq)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] ia;
      logic [15:0] da;
      logic        we;
      logic [15:0] wd;
      logic [7:0]  sw;
      logic        ci;
      logic [15:0] ei;
      logic        cd;
      logic [15:0] ed;
      logic [7:0]  eled;
      logic        eirq;
   } vec_t;

   typedef struct {
      logic        ci;
      logic [15:0] ei;
      logic        cd;
      logic [15:0] ed;
      logic [7:0]  eled;
      logic        eirq;
   } exp_t;

   exp_t sb[$];

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // One access cycle: drive, queue expectation, sample 1 time unit after the edge.
   task automatic cyc(input logic g, input vec_t v);
      exp_t e;
      gwe          = g;
      imem_addr    = v.ia;
      dmem_addr    = v.da;
      dmem_we      = v.we;
      dmem_towrite = v.wd;
      switch_data  = v.sw;
      sb.push_back('{v.ci, v.ei, v.cd, v.ed, v.eled, v.eirq});
      @(posedge clk);
      #1;
      e = sb.pop_front();
      if (e.ci) check("imem", imem_data, e.ei);
      if (e.cd) check("dmem", dmem_data, e.ed);
      check("led", {8'h00, led_data}, {8'h00, e.eled});
      check("irq", {15'h0, timer_irq}, {15'h0, e.eirq});
   endtask

   function automatic vec_t rd(input logic [15:0] da, input logic [15:0] ed,
                               input logic [7:0] eled, input logic eirq);
      return '{16'hFE00, da, 1'b0, 16'h0, 8'h00, 1'b1, 16'h0, 1'b1, ed, eled, eirq};
   endfunction

   function automatic vec_t wr(input logic [15:0] da, input logic [15:0] wd,
                               input logic cd, input logic [15:0] ed,
                               input logic [7:0] eled, input logic eirq);
      return '{16'hFE00, da, 1'b1, wd, 8'h00, 1'b1, 16'h0, cd, ed, eled, eirq};
   endfunction

   vec_t tbl[14];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      //        ia        da        we    wd        sw     ci    ei        cd    ed        led    irq
      tbl[0]  = '{16'hFE00, 16'h0005, 1'b1, 16'h1234, 8'h00, 1'b1, 16'h0000, 1'b0, 16'h0000, 8'h00, 1'b0};
      tbl[1]  = '{16'h0005, 16'h0005, 1'b0, 16'h0000, 8'h00, 1'b1, 16'h1234, 1'b1, 16'h1234, 8'h00, 1'b0};
      tbl[2]  = '{16'h0405, 16'h0405, 1'b0, 16'h0000, 8'h00, 1'b1, 16'h1234, 1'b1, 16'h1234, 8'h00, 1'b0};
      tbl[3]  = '{16'h0005, 16'h0005, 1'b1, 16'hBEEF, 8'h00, 1'b1, 16'h1234, 1'b1, 16'h1234, 8'h00, 1'b0};
      tbl[4]  = '{16'hFFFF, 16'h0005, 1'b0, 16'h0000, 8'h00, 1'b1, 16'h0000, 1'b1, 16'hBEEF, 8'h00, 1'b0};
      tbl[5]  = '{16'h0005, 16'hFE02, 1'b1, 16'h01A5, 8'h00, 1'b1, 16'hBEEF, 1'b1, 16'h0000, 8'hA5, 1'b0};
      tbl[6]  = '{16'hFE00, 16'hFE02, 1'b0, 16'h0000, 8'h00, 1'b1, 16'h0000, 1'b1, 16'h00A5, 8'hA5, 1'b0};
      tbl[7]  = '{16'hFE00, 16'hFE00, 1'b0, 16'h0000, 8'h3C, 1'b1, 16'h0000, 1'b1, 16'h003C, 8'hA5, 1'b0};
      tbl[8]  = '{16'hFE00, 16'hFE00, 1'b1, 16'hFFFF, 8'h3C, 1'b1, 16'h0000, 1'b1, 16'h003C, 8'hA5, 1'b0};
      tbl[9]  = '{16'hFE00, 16'hFE04, 1'b0, 16'h0000, 8'h3C, 1'b1, 16'h0000, 1'b1, 16'h0000, 8'hA5, 1'b0};
      tbl[10] = '{16'hFE00, 16'h0204, 1'b1, 16'h7777, 8'h00, 1'b1, 16'h0000, 1'b0, 16'h0000, 8'hA5, 1'b0};
      tbl[11] = '{16'hFE00, 16'hFE04, 1'b1, 16'h1111, 8'h00, 1'b1, 16'h0000, 1'b1, 16'h0000, 8'hA5, 1'b0};
      tbl[12] = '{16'h0204, 16'h0204, 1'b0, 16'h0000, 8'h00, 1'b1, 16'h7777, 1'b1, 16'h7777, 8'hA5, 1'b0};
      tbl[13] = '{16'hFE00, 16'hFE0A, 1'b0, 16'h0000, 8'h00, 1'b1, 16'h0000, 1'b1, 16'h0000, 8'hA5, 1'b0};

      // Reset with gwe high: everything reads zero.
      rst = 1'b1;
      cyc(1'b1, rd(16'h0005, 16'h0000, 8'h00, 1'b0));
      cyc(1'b1, rd(16'hFE00, 16'h0000, 8'h00, 1'b0));
      rst = 1'b0;
      cyc(1'b1, rd(16'hFE08, 16'h0000, 8'h00, 1'b0));

      for (int i = 0; i < 14; i++) cyc(1'b1, tbl[i]);

`ifdef LC4_TIMER_EN
      cyc(1'b1, wr(16'hFE0A, 16'h0003, 1'b1, 16'h0000, 8'hA5, 1'b0));
      cyc(1'b1, rd(16'hFE04, 16'h0000, 8'hA5, 1'b0));
      cyc(1'b1, rd(16'hFE04, 16'h0000, 8'hA5, 1'b0));
      cyc(1'b1, rd(16'hFE04, 16'h0000, 8'hA5, 1'b1));
      cyc(1'b1, rd(16'hFE08, 16'h8000, 8'hA5, 1'b0));
      cyc(1'b1, rd(16'hFE04, 16'h0000, 8'hA5, 1'b0));
      cyc(1'b1, rd(16'hFE04, 16'h0000, 8'hA5, 1'b1));
      cyc(1'b1, rd(16'hFE08, 16'h8000, 8'hA5, 1'b0));
      cyc(1'b1, rd(16'hFE04, 16'h0000, 8'hA5, 1'b0));
      // Status read lands on the expiry edge: the set wins.
      cyc(1'b1, rd(16'hFE08, 16'h0000, 8'hA5, 1'b1));
      cyc(1'b1, rd(16'hFE0A, 16'h0003, 8'hA5, 1'b1));
      for (int i = 0; i < 5; i++)
         cyc(1'b0, wr(16'h0005, 16'hDEAD, 1'b1, 16'h0003, 8'hA5, 1'b1));
      cyc(1'b1, rd(16'hFE08, 16'h8000, 8'hA5, 1'b0));
      cyc(1'b1, rd(16'h0005, 16'hBEEF, 8'hA5, 1'b1));
`else
      cyc(1'b1, wr(16'hFE0A, 16'h0002, 1'b1, 16'h0000, 8'hA5, 1'b0));
      for (int i = 0; i < 10; i++) cyc(1'b1, rd(16'hFE04, 16'h0000, 8'hA5, 1'b0));
      cyc(1'b1, rd(16'hFE08, 16'h0000, 8'hA5, 1'b0));
      cyc(1'b1, rd(16'hFE0A, 16'h0000, 8'hA5, 1'b0));
      cyc(1'b1, rd(16'h0005, 16'hBEEF, 8'hA5, 1'b0));
      for (int i = 0; i < 5; i++)
         cyc(1'b0, wr(16'h0005, 16'hDEAD, 1'b1, 16'hBEEF, 8'hA5, 1'b0));
      cyc(1'b1, rd(16'h0005, 16'hBEEF, 8'hA5, 1'b0));
`endif

      // Asynchronous reset in mid-cycle, held over a pending RAM write.
      gwe          = 1'b1;
      dmem_addr    = 16'h0005;
      dmem_we      = 1'b1;
      dmem_towrite = 16'h5555;
      #3;
      rst = 1'b1;
      #1;
      check("async_rst_led", {8'h00, led_data}, 16'h0000);
      check("async_rst_dmem", dmem_data, 16'h0000);
      check("async_rst_irq", {15'h0, timer_irq}, 16'h0000);
      @(posedge clk);
      #1;
      rst = 1'b0;
      cyc(1'b1, rd(16'h0005, 16'hBEEF, 8'h00, 1'b0));
      cyc(1'b1, rd(16'hFE0A, 16'h0000, 8'h00, 1'b0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/lc4_mem_responder.md
# lc4_mem_responder

Memory-side responder for the LC4 pipelined core. It services the core's instruction-fetch port and its data-memory port from one shared word-addressed RAM. It also decodes a small memory-mapped I/O page that holds switch input, an LED output register and an interval timer. The block sits between `lc4_processor` and the board top level, and replaces the raw switch-to-LED passthrough.

## Interface
Parameters:
- `ADDR_BITS`, default 10: the RAM holds 2^ADDR_BITS 16-bit words.
- `TIMER_BITS`, default 16: width of the timer down-counter; must be 16 or more.

Ports:
- `clk` in 1: the single clock. All state updates on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `gwe` in 1: global write enable. No register or RAM update occurs while it is low.
- `i_imem_addr` in 16: instruction fetch address.
- `o_imem_data` out 16: fetched word.
- `i_dmem_addr` in 16: data access address.
- `i_dmem_we` in 1: data write enable.
- `i_dmem_towrite` in 16: data to write.
- `o_dmem_data` out 16: data read result.
- `i_switch_data` in 8: board switches.
- `o_led_data` out 8: board LEDs.
- `o_timer_irq` out 1: timer expired flag.

## Operation
Address map (word addresses):
- `0x0000`–`0xFDFF`: RAM, indexed by `addr[ADDR_BITS-1:0]`. Higher address bits are ignored, so the RAM aliases across this range.
- `0xFE00` SWR: reads `{8'h00, i_switch_data}`. Writes are ignored.
- `0xFE02` LEDR: reads `{8'h00, led}`. A write stores `towrite[7:0]`.
- `0xFE08` TSR: reads `{flag, 15'h0}`. A gwe-qualified read clears the flag. Writes are ignored.
- `0xFE0A` TIR: reads and writes the interval, zero-extended or truncated to 16 bits.
- Any other address at `0xFE00` or above: reads 0, writes are dropped.

Instruction port:
- Read-only.
- Returns the RAM word for addresses below `0xFE00`, and 0 otherwise.

Timer:
- The counter `cnt` and the `flag` update only on gwe cycles.
- When TIR = 0 the timer is idle and `cnt` is held at 0.
- A write to TIR loads `cnt` with the new value. `flag` is unchanged.
- Otherwise, on each gwe cycle with TIR ≠ 0:
  - if `cnt` ≤ 1: set `flag` and reload `cnt` from TIR;
  - else: decrement `cnt`.
- If an expiry and a TSR read fall in the same cycle, set wins and `flag` stays 1.
- `o_timer_irq` equals `flag`.

## Timing
- Reads have one cycle of latency. The address is sampled at a gwe-qualified rising edge, and data is valid on `o_imem_data` and `o_dmem_data` after that edge. With gwe low, the outputs hold.
- Writes commit at the gwe-qualified edge on which `i_dmem_we` = 1.
- Read and write to the same RAM word on the same edge: read-first. `o_dmem_data` returns the old word, and the new word is visible from the next access.
- Instruction and data reads of the same address in the same cycle both return the same old data.
- A TSR clear and an LED or TIR update take effect at the access edge. `o_led_data` and `o_timer_irq` change after that edge.
- Reset values: `o_imem_data`, `o_dmem_data`, `o_led_data` and `o_timer_irq` are 0; `flag` = 0, TIR = 0, `cnt` = 0.
- RAM contents are not reset.
- Reset asserted mid-access drops any write pending on that edge and clears all registers immediately, without waiting for `clk`.

## Configuration
- `LC4_TIMER_EN` defined: timer logic, TSR and TIR are built as described above.
- `LC4_TIMER_EN` undefined:
  - no timer logic is built;
  - TSR and TIR read 0 and writes to them are dropped;
  - `o_timer_irq` is tied to 0.
  - RAM, SWR and LEDR behaviour is unchanged.

## Test plan
- Reset check: assert `rst` with `gwe` = 1 → all outputs read 0. Deassert, then read TSR → `0x0000`.
- RAM write/read: write `0x1234` to `0x0005`, then read `0x0005` on the data port and the instruction port → both return `0x1234` one cycle later. A data read of `0x0405` with `ADDR_BITS` = 10 → `0x1234` (alias).
- Read-during-write: with `0x0005` = `0x1234`, read and write `0xBEEF` to it on the same edge → `o_dmem_data` = `0x1234`. Next read → `0xBEEF`.
- I/O page:
  - write `0x01A5` to `0xFE02` → `o_led_data` = `0xA5`, and a read of `0xFE02` returns `0x00A5`;
  - `i_switch_data` = `0x3C`, read `0xFE00` → `0x003C`;
  - read `0xFE04` → `0x0000`.
- Timer (`LC4_TIMER_EN` defined):
  - write TIR = 3 → `o_timer_irq` rises after the 3rd gwe cycle;
  - read TSR → `0x8000`, and irq falls after that edge;
  - irq rises again 3 gwe cycles after the reload;
  - a TSR read on the expiry cycle leaves irq = 1.
- gwe gating and macro off:
  - with `gwe` low for 5 cycles, a RAM write and the timer do not advance;
  - with `LC4_TIMER_EN` undefined, write TIR = 2 and wait 10 cycles → TSR and TIR read 0 and `o_timer_irq` = 0.
